// File: rtl/arrow_pkg.sv
// Shared constants for the arrow glyph renderer: class indices, glyph ROM,
// FSM state encoding and the one-hot decode helper.
package arrow_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  localparam logic [2:0] ARROW_UP        = 3'd0;
  localparam logic [2:0] ARROW_UPLEFT    = 3'd1;
  localparam logic [2:0] ARROW_LEFTDOWN  = 3'd2;
  localparam logic [2:0] ARROW_LEFT      = 3'd3;
  localparam logic [2:0] ARROW_DOWN      = 3'd4;
  localparam logic [2:0] ARROW_UPRIGHT   = 3'd5;
  localparam logic [2:0] ARROW_DOWNRIGHT = 3'd6;
  localparam logic [2:0] ARROW_RIGHT     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Row 0 is the top row; MSB is the leftmost pixel.
  localparam logic [COLS-1:0] GLYPH [8][ROWS] = '{
    '{16'h0000, 16'h0000, 16'h0100, 16'h0380, 16'h07C0, 16'h0FE0, 16'h1FF0, 16'h0380,
      16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h3F80, 16'h3F00, 16'h3E00, 16'h3F00, 16'h3B80, 16'h31C0,
      16'h20E0, 16'h0070, 16'h0038, 16'h001C, 16'h000C, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h000C, 16'h001C, 16'h0038, 16'h0070, 16'h20E0,
      16'h31C0, 16'h3B80, 16'h3F00, 16'h3E00, 16'h3F00, 16'h3F80, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0C00, 16'h1FFC, 16'h3FFC,
      16'h1FFC, 16'h0C00, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380,
      16'h0380, 16'h1FF0, 16'h0FE0, 16'h07C0, 16'h0380, 16'h0100, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h01FC, 16'h00FC, 16'h007C, 16'h00FC, 16'h01DC, 16'h038C,
      16'h0704, 16'h0E00, 16'h1C00, 16'h3800, 16'h3000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h3800, 16'h1C00, 16'h0E00, 16'h0704,
      16'h038C, 16'h01DC, 16'h00FC, 16'h007C, 16'h00FC, 16'h01FC, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 16'h0030, 16'h3FF8, 16'h3FFC,
      16'h3FF8, 16'h0030, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}
  };

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arrow_renderer_if.sv
// Command, row-stream and frame signals of the arrow renderer.
// master drives commands and row_ready; slave is the renderer.
interface arrow_renderer_if;
  import arrow_pkg::*;

  logic [7:0]           cmd_class;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [COLS-1:0]      row_data;
  logic [3:0]           row_idx;
  logic                 row_valid;
  logic                 row_ready;
  logic                 row_last;
  logic [ROWS*COLS-1:0] pixel_vector;
  logic                 frame_valid;
  logic                 cmd_err;
  logic                 busy;

  modport master (
    output cmd_class, cmd_valid, row_ready,
    input  cmd_ready, row_data, row_idx, row_valid, row_last,
           pixel_vector, frame_valid, cmd_err, busy
  );

  modport slave (
    input  cmd_class, cmd_valid, row_ready,
    output cmd_ready, row_data, row_idx, row_valid, row_last,
           pixel_vector, frame_valid, cmd_err, busy
  );

endinterface

// File: rtl/arrow_glyph_rom.sv
// Combinational glyph row lookup from the package ROM constant.
module arrow_glyph_rom
  import arrow_pkg::*;
(
  input  logic [2:0]      cls,
  input  logic [3:0]      row,
  output logic [COLS-1:0] row_data
);

  always_comb begin
    row_data = GLYPH[cls][row];
  end

endmodule

// File: rtl/arrow_renderer.sv
// Streams one arrow glyph row by row and publishes the completed frame.
//   state   | meaning
//   IDLE    | cmd_ready high; accept one-hot command or flag an illegal one
//   EMIT    | present glyph row `row`; advance on row handshake
//   DONE    | new frame visible on pixel_vector, frame_valid pulse
module arrow_renderer
  import arrow_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  arrow_renderer_if.slave bus
);

  state_t state, state_nxt;

  logic [2:0]               cls;
  logic [3:0]               row;
  logic [(ROWS-1)*COLS-1:0] acc;
  logic [ROWS*COLS-1:0]     frame;
  logic                     err;
  logic [COLS-1:0]          glyph_row;
  logic                     cmd_ok, accept, reject, handshake, last_hs;

  assign cmd_ok    = ($countones(bus.cmd_class) == 1);
  assign accept    = (state == ST_IDLE) && bus.cmd_valid && cmd_ok;
  assign reject    = (state == ST_IDLE) && bus.cmd_valid && !cmd_ok;
  assign handshake = (state == ST_EMIT) && bus.row_ready;
  assign last_hs   = handshake && (row == 4'(ROWS-1));

  arrow_glyph_rom u_rom (
    .cls      (cls),
    .row      (row),
    .row_data (glyph_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept)  state_nxt = ST_EMIT;
      ST_EMIT: if (last_hs) state_nxt = ST_DONE;
      ST_DONE:              state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready    = (state == ST_IDLE);
    bus.busy         = (state != ST_IDLE);
    bus.row_valid    = (state == ST_EMIT);
    bus.row_data     = (state == ST_EMIT) ? glyph_row : '0;
    bus.row_idx      = row;
    bus.row_last     = (state == ST_EMIT) && (row == 4'(ROWS-1));
    bus.frame_valid  = (state == ST_DONE);
    bus.cmd_err      = err;
    bus.pixel_vector = frame;
  end

  // The last row bypasses acc so the frame register is loaded on the final
  // handshake and is already visible during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls   <= '0;
      row   <= '0;
      acc   <= '0;
      frame <= '0;
      err   <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        cls <= onehot_to_idx(bus.cmd_class);
        row <= '0;
        acc <= '0;
      end else if (handshake) begin
        row <= row + 4'd1;
        acc <= {acc[(ROWS-2)*COLS-1:0], glyph_row};
        if (last_hs) frame <= {acc, glyph_row};
      end
    end
  end

endmodule

// File: tb/tb_arrow_renderer.sv
// Self-checking bench for arrow_renderer: row stream and frame scoreboard.
module tb_arrow_renderer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arrow_renderer_if bus();

  arrow_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [15:0] TB_GLYPH [8][16] = '{
    '{16'h0000, 16'h0000, 16'h0100, 16'h0380, 16'h07C0, 16'h0FE0, 16'h1FF0, 16'h0380,
      16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h3F80, 16'h3F00, 16'h3E00, 16'h3F00, 16'h3B80, 16'h31C0,
      16'h20E0, 16'h0070, 16'h0038, 16'h001C, 16'h000C, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h000C, 16'h001C, 16'h0038, 16'h0070, 16'h20E0,
      16'h31C0, 16'h3B80, 16'h3F00, 16'h3E00, 16'h3F00, 16'h3F80, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0C00, 16'h1FFC, 16'h3FFC,
      16'h1FFC, 16'h0C00, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380, 16'h0380,
      16'h0380, 16'h1FF0, 16'h0FE0, 16'h07C0, 16'h0380, 16'h0100, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h01FC, 16'h00FC, 16'h007C, 16'h00FC, 16'h01DC, 16'h038C,
      16'h0704, 16'h0E00, 16'h1C00, 16'h3800, 16'h3000, 16'h0000, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h3800, 16'h1C00, 16'h0E00, 16'h0704,
      16'h038C, 16'h01DC, 16'h00FC, 16'h007C, 16'h00FC, 16'h01FC, 16'h0000, 16'h0000},
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0020, 16'h0030, 16'h3FF8, 16'h3FFC,
      16'h3FF8, 16'h0030, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}
  };

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
  } row_t;

  row_t         exp_q[$];
  logic [255:0] frame_q[$];
  logic [255:0] last_frame = '0;

  function automatic logic [15:0] pv_row(input logic [255:0] pv, input int r);
    return pv[255-16*r -: 16];
  endfunction

  task automatic push_glyph(input int c);
    logic [255:0] f;
    f = '0;
    for (int r = 0; r < 16; r++) begin
      exp_q.push_back('{idx: 4'(r), data: TB_GLYPH[c][r]});
      f = {f[239:0], TB_GLYPH[c][r]};
    end
    frame_q.push_back(f);
  endtask

  // Call at a negedge; returns the index of the accepting posedge.
  task automatic issue(input logic [7:0] oh, input int c, output int a);
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: cmd_ready=%b expected 1", bus.cmd_ready);
    end
    bus.cmd_class = oh;
    bus.cmd_valid = 1'b1;
    a = cyc + 1;
    push_glyph(c);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_class = 8'h00;
  endtask

  // Runs one frame from relative cycle 0; fv_rel is the cycle offset of frame_valid.
  task automatic consume(input int a, input bit toggle, output int fv_rel);
    row_t         e;
    int           hs;
    bit           stalled, hold_ok;
    logic [19:0]  prev;
    logic [255:0] f;
    hs = 0; stalled = 0; hold_ok = 1; prev = '0; fv_rel = -1;
    for (int k = 0; k < 64 && fv_rel < 0; k++) begin
      bus.row_ready = toggle ? (((cyc - a) % 2) == 0) : 1'b1;
      if (bus.row_valid) begin
        if (stalled) begin
          total++;
          if ({bus.row_idx, bus.row_data} !== prev) begin
            bad++;
            $display("FAIL stall_stable: idx/data=%h expected %h", {bus.row_idx, bus.row_data}, prev);
          end
        end
        if (bus.row_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_row: idx=%0d data=%h with no row expected", bus.row_idx, bus.row_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.row_idx, bus.row_data, bus.row_last} !== {e.idx, e.data, (e.idx == 4'd15)}) begin
              bad++;
              $display("FAIL row: idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                       bus.row_idx, bus.row_data, bus.row_last, e.idx, e.data, (e.idx == 4'd15));
            end
          end
          hs++;
        end
        stalled = !bus.row_ready;
        prev    = {bus.row_idx, bus.row_data};
      end
      if (bus.frame_valid) begin
        fv_rel = cyc - a;
        f = (frame_q.size() > 0) ? frame_q.pop_front() : '0;
        total++;
        if (bus.pixel_vector !== f) begin
          bad++;
          $display("FAIL frame: pixel_vector=%h expected %h", bus.pixel_vector, f);
        end
        total++;
        if (hs != 16) begin
          bad++;
          $display("FAIL handshakes: got %0d expected 16", hs);
        end
        last_frame = f;
      end else if (bus.pixel_vector !== last_frame) begin
        hold_ok = 0;
      end
      @(negedge clk);
    end
    total++;
    if (!hold_ok) begin
      bad++;
      $display("FAIL frame_hold: pixel_vector changed before frame_valid, now %h expected %h",
               bus.pixel_vector, last_frame);
    end
    if (fv_rel < 0) begin
      total++; bad++;
      $display("FAIL frame_timeout: no frame_valid within 64 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.cmd_ready, bus.row_valid, bus.row_data, bus.row_idx, bus.row_last,
         bus.frame_valid, bus.cmd_err, bus.busy} !== {1'b1, 25'd0} || bus.pixel_vector !== '0) begin
      bad++;
      $display("FAIL reset_values: ready=%b rv=%b rd=%h ri=%0d rl=%b fv=%b err=%b busy=%b pv=%h",
               bus.cmd_ready, bus.row_valid, bus.row_data, bus.row_idx, bus.row_last,
               bus.frame_valid, bus.cmd_err, bus.busy, bus.pixel_vector);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.cmd_ready, bus.row_valid, bus.busy, bus.cmd_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_idle_pulse: ready/rv/busy/err=%b expected 1000",
               {bus.cmd_ready, bus.row_valid, bus.busy, bus.cmd_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: cmd_ready=%b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_all_classes;
    int a, fv;
    logic [15:0] ref_got, ref_exp;
    for (int c = 0; c < 8; c++) begin
      issue(8'(1 << c), c, a);
      consume(a, 1'b0, fv);
      total++;
      if (fv != 16) begin
        bad++;
        $display("FAIL class%0d_fv_cycle: frame_valid at T0+%0d expected T0+17", c, fv + 1);
      end
      total++;
      if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
        bad++;
        $display("FAIL class%0d_ready_return: ready/busy=%b expected 10", c, {bus.cmd_ready, bus.busy});
      end
      total++;
      if ({bus.pixel_vector[255:224], bus.pixel_vector[31:0]} !== 64'd0) begin
        bad++;
        $display("FAIL class%0d_blank_rows: rows0,1,14,15=%h expected 0", c,
                 {bus.pixel_vector[255:224], bus.pixel_vector[31:0]});
      end
      ref_got = 16'h0; ref_exp = 16'h0;
      case (c)
        0: begin ref_got = pv_row(bus.pixel_vector, 6); ref_exp = 16'h1FF0; end
        1: begin ref_got = pv_row(bus.pixel_vector, 2); ref_exp = 16'h3F80; end
        3: begin ref_got = pv_row(bus.pixel_vector, 7); ref_exp = 16'h3FFC; end
        4: begin ref_got = pv_row(bus.pixel_vector, 9); ref_exp = 16'h1FF0; end
        default: ;
      endcase
      if (c == 0 || c == 1 || c == 3 || c == 4) begin
        total++;
        if (ref_got !== ref_exp) begin
          bad++;
          $display("FAIL class%0d_ref_row: got %h expected %h", c, ref_got, ref_exp);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int a, fv;
    issue(8'h80, 7, a);
    consume(a, 1'b1, fv);
    total++;
    if (fv != 31) begin
      bad++;
      $display("FAIL bp_fv_cycle: frame_valid at T0+%0d expected T0+32", fv + 1);
    end
    total++;
    if (pv_row(bus.pixel_vector, 7) !== 16'h3FFC) begin
      bad++;
      $display("FAIL bp_right_row7: got %h expected 3FFC", pv_row(bus.pixel_vector, 7));
    end
  endtask

  task automatic test_illegal;
    logic [7:0] code;
    for (int i = 0; i < 2; i++) begin
      code = (i == 0) ? 8'h00 : 8'h03;
      bus.cmd_class = code;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_class = 8'h00;
      total++;
      if ({bus.cmd_err, bus.row_valid, bus.busy, bus.cmd_ready} !== 4'b1001) begin
        bad++;
        $display("FAIL illegal_%h_err: err/rv/busy/ready=%b expected 1001", code,
                 {bus.cmd_err, bus.row_valid, bus.busy, bus.cmd_ready});
      end
      total++;
      if (bus.pixel_vector !== last_frame) begin
        bad++;
        $display("FAIL illegal_%h_frame: pixel_vector=%h expected %h", code, bus.pixel_vector, last_frame);
      end
      @(negedge clk);
      total++;
      if ({bus.cmd_err, bus.row_valid, bus.busy} !== 3'b000) begin
        bad++;
        $display("FAIL illegal_%h_pulse: err/rv/busy=%b expected 000", code,
                 {bus.cmd_err, bus.row_valid, bus.busy});
      end
    end
  endtask

  task automatic test_back_to_back;
    int a1, a2, fv;
    bus.cmd_class = 8'h02;
    bus.cmd_valid = 1'b1;
    a1 = cyc + 1;
    push_glyph(1);
    @(negedge clk);
    bus.cmd_class = 8'h10;
    consume(a1, 1'b0, fv);
    total++;
    if (fv != 16 || bus.cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: fv at T0+%0d ready=%b expected T0+17 and ready 1", fv + 1, bus.cmd_ready);
    end
    a2 = cyc + 1;
    push_glyph(4);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_class = 8'h00;
    consume(a2, 1'b0, fv);
    total++;
    if (fv != 16) begin
      bad++;
      $display("FAIL b2b_second: frame_valid at T0+%0d expected T0+17", fv + 1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int a, fv, fv_seen;
    bit found;
    issue(8'h08, 3, a);
    bus.row_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (bus.row_valid && bus.row_idx == 4'd5) found = 1;
      else @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midreset_reach_row5: row_idx=%0d expected 5", bus.row_idx);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.cmd_ready, bus.row_valid, bus.row_data, bus.row_idx, bus.row_last,
         bus.frame_valid, bus.cmd_err, bus.busy} !== {1'b1, 25'd0} || bus.pixel_vector !== '0) begin
      bad++;
      $display("FAIL midreset_values: ready=%b rv=%b rd=%h ri=%0d busy=%b pv=%h",
               bus.cmd_ready, bus.row_valid, bus.row_data, bus.row_idx, bus.busy, bus.pixel_vector);
    end
    exp_q.delete();
    frame_q.delete();
    last_frame = '0;
    @(negedge clk);
    rst_n = 1'b1;
    fv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_valid) fv_seen++;
    end
    total++;
    if (fv_seen != 0) begin
      bad++;
      $display("FAIL midreset_no_frame: frame_valid seen %0d times expected 0", fv_seen);
    end
    issue(8'h01, 0, a);
    consume(a, 1'b0, fv);
    total++;
    if (fv != 16 || pv_row(bus.pixel_vector, 3) !== 16'h0380) begin
      bad++;
      $display("FAIL midreset_up_after: fv at T0+%0d row3=%h expected T0+17 and 0380",
               fv + 1, pv_row(bus.pixel_vector, 3));
    end
  endtask

  initial begin
    bus.cmd_class = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.row_ready = 1'b0;
    test_reset();
    test_all_classes();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arrow_renderer.md
# arrow_renderer

- Renders one of the eight 16×16 arrow glyphs from a one-hot class code, the inverse of the arrow classifier, which maps a 256-bit pixel_vector to a one-hot neuron_out.
- Accepts a command over a valid/ready handshake, streams the glyph out one 16-bit row per handshake, and presents the assembled 256-bit frame on pixel_vector when the last row completes.
- Used as a stimulus source and loopback partner for the classifier, and as the display-side producer for the row-oriented pixel path.

## Interface
- ROWS, 16, rows per frame; only 16 supported, because the glyph ROM is fixed.
- COLS, 16, pixels per row; only 16 supported.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_class  in  8  one-hot class: bit0 UP, 1 UPLEFT, 2 LEFTDOWN, 3 LEFT, 4 DOWN, 5 UPRIGHT, 6 DOWNRIGHT, 7 RIGHT (same encoding as neuron_out).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- row_data  out  COLS  current row; MSB is the leftmost pixel, 1 means set.
- row_idx  out  4  row number, 0 is the top row.
- row_valid  out  1  row_data/row_idx valid.
- row_ready  in  1  consumer accepts the row.
- row_last  out  1  high with row_valid when row_idx==15.
- pixel_vector  out  256  last complete frame; row 0 occupies [255:240], row 15 occupies [15:0].
- frame_valid  out  1  one-cycle pulse when pixel_vector is updated.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- busy  out  1  high while not in IDLE.

## Operation
- FSM states are IDLE, EMIT and DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with popcount(cmd_class)==1: latch the class index (0..7), set row=0, clear the accumulator, go to EMIT.
  - On cmd_valid with popcount(cmd_class)!=1 (covers 0 and multi-hot): pulse cmd_err for the next cycle and stay in IDLE. No rows are emitted and pixel_vector is unchanged.
- EMIT:
  - row_valid=1, row_data=glyph[cls][row], row_idx=row.
  - Outputs hold stable while row_ready=0.
  - On handshake (row_valid & row_ready): shift the row into the accumulator (acc <= {acc[239:0], row_data}) and increment row.
  - Handshake at row 15: go to DONE.
- DONE:
  - pixel_vector <= accumulator and frame_valid=1, both for this one cycle.
  - Go to IDLE.
- pixel_vector never shows a partial frame. It holds the previous frame until the new frame completes.
- cmd_class and cmd_valid are ignored outside IDLE. A held cmd_valid is accepted on the first IDLE cycle.
- No combinational path from any input to any output, except that row_valid and row_data do not depend on row_ready within the same cycle.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1.
  - row_valid=0, row_data=0, row_idx=0, row_last=0.
  - pixel_vector=0, frame_valid=0, cmd_err=0, busy=0.
- Command accepted at edge T0:
  - first row_valid in cycle T0+1;
  - with row_ready held high, rows 0..15 complete in cycles T0+1..T0+16;
  - frame_valid and the new pixel_vector appear in cycle T0+17;
  - cmd_ready returns in cycle T0+18.
  - Minimum command-to-command period is 18 cycles.
- Each cycle with row_ready=0 in EMIT adds exactly one cycle to the frame.
- cmd_err asserts in the cycle after the rejected cmd_valid. cmd_ready stays 1 throughout the rejection.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronous). The partial frame is discarded and pixel_vector=0.
- Counter width is 4 bits. It wraps only on the DONE transition and is reloaded to 0 on accept.

## Structure
- Package arrow_pkg contains:
  - class index constants ARROW_UP=0 … ARROW_RIGHT=7;
  - the glyph ROM constant, an 8×16 array of 16-bit rows;
  - the state enum;
  - a onehot_to_idx function.
- Sub-module arrow_glyph_rom: combinational lookup (cls[2:0], row[3:0]) → row_data[15:0], drawn from the package constant.
- Reference rows checked by the bench:
  - UP row 2 = 16'h0100, UP row 3 = 16'h0380, UP row 6 = 16'h1FF0;
  - RIGHT and LEFT row 7 = 16'h3FFC;
  - UPLEFT row 2 = 16'h3F80;
  - DOWN row 9 = 16'h1FF0;
  - rows 0, 1, 14 and 15 are 16'h0000 for every glyph.

## Test plan
- Reset: pulse rst_n low mid-idle → every output equals its reset value; cmd_ready=1 immediately after release.
- UP with row_ready=1: cmd_class=8'h01 → row_data sequence 0000,0000,0100,0380,…,1FF0 at row 6 …,0000; frame_valid in cycle T0+17; pixel_vector equals the full UP glyph. Feeding it into the classifier gives neuron_out=8'h01. Repeat for all 8 classes.
- Backpressure, RIGHT (8'h80) with row_ready toggling 1,0: row_data and row_idx stay stable on stall cycles; row 7 = 3FFC; frame_valid after exactly 16 handshakes (cycle T0+32).
- Illegal commands 8'h00 and 8'h03 → cmd_err high for one cycle, row_valid stays 0, pixel_vector unchanged, busy stays 0.
- Back-to-back: UPLEFT then DOWN with cmd_valid held → DOWN accepted only at T0+18; pixel_vector holds UPLEFT until the DOWN frame's frame_valid.
- Reset at row_idx 5 during LEFT → outputs clear, no frame_valid, and the next UP command renders correctly.
